riscv_core_icache_controller: RTL and testbench

Sequencing controller for the direct-mapped instruction cache data array (32 B blocks, 128 sets, 64-bit addresses). It owns the tag/valid store and performs hit/miss lookup for 32-bit fetches at any halfword-aligned address, including fetches that straddle two blocks (RVC). It issues AXI block refills and drives the data array's read, write, replace and offset controls. It sits between the fetch stage, the icache data array and the AXI read master.

---
 rtl/riscv_core_icache_pkg.sv | 23 ++
 rtl/riscv_core_icache_tag_array.sv | 50 +++++
 rtl/riscv_core_icache_controller.sv | 140 ++++++++++++++
 tb/tb_riscv_core_icache_controller.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_icache_pkg.sv
// Shared constants for the instruction cache controller: default widths,
// address field positions and FSM state encodings.
package riscv_core_icache_pkg;

  localparam int ADDR_WIDTH_DEF         = 64;
  localparam int INDEX_WIDTH_DEF        = 7;
  localparam int TAG_WIDTH_DEF          = 52;
  localparam int BLOCK_OFFSET_WIDTH_DEF = 3;
  localparam int CNT_WIDTH_DEF          = 32;

  localparam int TAG_MSB          = 63;
  localparam int TAG_LSB          = 12;
  localparam int INDEX_MSB        = 11;
  localparam int INDEX_LSB        = 5;
  localparam int BLOCK_OFFSET_MSB = 4;
  localparam int BLOCK_OFFSET_LSB = 2;
  localparam int BYTE_OFFSET_MSB  = 1;
  localparam int BYTE_OFFSET_LSB  = 0;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_REFILL = 1'b1;

endpackage

// File: rtl/riscv_core_icache_tag_array.sv
// Direct-mapped tag/valid store: two combinational lookup ports, one
// synchronous write port and a single-cycle invalidate-all.
module riscv_core_icache_tag_array
  import riscv_core_icache_pkg::*;
#(
  parameter int INDEX_WIDTH = INDEX_WIDTH_DEF,
  parameter int TAG_WIDTH   = TAG_WIDTH_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [INDEX_WIDTH-1:0] i_rd_idx0,
  input  logic [INDEX_WIDTH-1:0] i_rd_idx1,
  output logic                   o_valid0,
  output logic [TAG_WIDTH-1:0]   o_tag0,
  output logic                   o_valid1,
  output logic [TAG_WIDTH-1:0]   o_tag1,
  input  logic                   i_wr_en,
  input  logic [INDEX_WIDTH-1:0] i_wr_idx,
  input  logic [TAG_WIDTH-1:0]   i_wr_tag,
  input  logic                   i_flush
);

  localparam int SETS = 1 << INDEX_WIDTH;

  logic [SETS-1:0]      r_valid;
  logic [TAG_WIDTH-1:0] r_tag [SETS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tags carry no reset: an entry is only trusted while its valid bit is set.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx] <= i_wr_tag;
    end
  end

  assign o_valid0 = r_valid[i_rd_idx0];
  assign o_tag0   = r_tag[i_rd_idx0];
  assign o_valid1 = r_valid[i_rd_idx1];
  assign o_tag1   = r_tag[i_rd_idx1];

endmodule

// File: rtl/riscv_core_icache_controller.sv
// Instruction cache sequencing controller: hit/miss lookup for 32-bit fetches
// (including block-straddling ones), AXI block refill and data array control.
module riscv_core_icache_controller
  import riscv_core_icache_pkg::*;
#(
  parameter int ADDR_WIDTH         = ADDR_WIDTH_DEF,
  parameter int INDEX_WIDTH        = INDEX_WIDTH_DEF,
  parameter int TAG_WIDTH          = TAG_WIDTH_DEF,
  parameter int BLOCK_OFFSET_WIDTH = BLOCK_OFFSET_WIDTH_DEF,
  parameter int CNT_WIDTH          = CNT_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_addr_from_core,
  input  logic                  i_req,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic                  o_fetch_err,
  output logic                  o_rd_en,
  output logic                  o_wr_en,
  output logic                  o_block_replace,
  output logic                  o_offset,
  output logic                  o_axi_rd_req,
  output logic [ADDR_WIDTH-1:0] o_axi_addr,
  input  logic                  i_axi_rd_valid,
  input  logic                  i_axi_rd_err,
  output logic [CNT_WIDTH-1:0]  o_miss_cnt
);

  localparam int IDX_LSB = BLOCK_OFFSET_WIDTH + 2;
  localparam int BLK_W   = ADDR_WIDTH - IDX_LSB;

  logic [0:0]           r_state;
  logic                 r_sel;
  logic [BLK_W-1:0]     r_blk;
  logic [CNT_WIDTH-1:0] r_miss_cnt;
  logic                 r_flush_pending;

  logic                 w_unused_bit0;
  logic                 w_span;
  logic [BLK_W-1:0]     w_blk0;
  logic [BLK_W-1:0]     w_blk2;
  logic                 w_valid0;
  logic                 w_valid1;
  logic [TAG_WIDTH-1:0] w_tag0;
  logic [TAG_WIDTH-1:0] w_tag1;
  logic                 w_hit0;
  logic                 w_hit1;
  logic                 w_hit;
  logic                 w_idle;
  logic                 w_refill;
  logic                 w_lookup;
  logic                 w_miss;
  logic                 w_fill_ok;
  logic                 w_fill_err;
  logic                 w_flush_all;

  // Work in block numbers: the second halfword's block is the first one plus
  // the carry out of the in-block offset, which also covers the 2^64 wrap.
  assign w_unused_bit0 = i_addr_from_core[0];
  assign w_span        = &i_addr_from_core[IDX_LSB-1:1];
  assign w_blk0        = i_addr_from_core[ADDR_WIDTH-1:IDX_LSB];
  assign w_blk2        = w_blk0 + {{(BLK_W-1){1'b0}}, w_span};

  riscv_core_icache_tag_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_tag_array (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_rd_idx0 (w_blk0[INDEX_WIDTH-1:0]),
    .i_rd_idx1 (w_blk2[INDEX_WIDTH-1:0]),
    .o_valid0  (w_valid0),
    .o_tag0    (w_tag0),
    .o_valid1  (w_valid1),
    .o_tag1    (w_tag1),
    .i_wr_en   (w_fill_ok),
    .i_wr_idx  (r_blk[INDEX_WIDTH-1:0]),
    .i_wr_tag  (r_blk[BLK_W-1:INDEX_WIDTH]),
    .i_flush   (w_flush_all)
  );

  assign w_hit0 = w_valid0 && (w_tag0 == w_blk0[BLK_W-1:INDEX_WIDTH]);
  assign w_hit1 = w_valid1 && (w_tag1 == w_blk2[BLK_W-1:INDEX_WIDTH]);
  assign w_hit  = w_hit0 && (!w_span || w_hit1);

  // Combinational outputs are gated by reset so everything reads 0 while held.
  assign w_idle      = (r_state == ST_IDLE) && i_rst_n;
  assign w_refill    = (r_state == ST_REFILL);
  assign w_lookup    = w_idle && !r_flush_pending && i_req;
  assign w_miss      = w_lookup && !w_hit;
  assign w_fill_ok   = w_refill && i_axi_rd_valid && !i_axi_rd_err;
  assign w_fill_err  = w_refill && i_axi_rd_valid && i_axi_rd_err;
  assign w_flush_all = w_idle && (i_flush || r_flush_pending);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= ST_IDLE;
      r_sel           <= 1'b0;
      r_blk           <= '0;
      r_miss_cnt      <= '0;
      r_flush_pending <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_flush_pending <= 1'b0;
          if (w_miss) begin
            r_state <= ST_REFILL;
            r_sel   <= w_hit0;
            r_blk   <= w_hit0 ? w_blk2 : w_blk0;
            if (r_miss_cnt != {CNT_WIDTH{1'b1}}) begin
              r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
            end
          end
        end
        ST_REFILL: begin
          // A fence.i seen mid-refill invalidates after the new block lands.
          if (i_flush) begin
            r_flush_pending <= 1'b1;
          end
          if (i_axi_rd_valid) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_stall         = w_refill || (w_idle && r_flush_pending) || w_miss;
  assign o_rd_en         = w_lookup && w_hit;
  assign o_wr_en         = w_fill_ok;
  assign o_block_replace = w_fill_ok;
  assign o_offset        = w_fill_ok && r_sel;
  assign o_fetch_err     = w_fill_err;
  assign o_axi_rd_req    = w_refill;
  assign o_axi_addr      = {r_blk, {IDX_LSB{1'b0}}};
  assign o_miss_cnt      = r_miss_cnt;

endmodule

// File: tb/tb_riscv_core_icache_controller.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized fetch/refill/flush traffic compared every cycle with a cache model.
module tb_riscv_core_icache_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [63:0]   addr;
  logic          req, flush, axv, axe;
  logic          o_stall, o_fetch_err, o_rd_en, o_wr_en, o_block_replace, o_offset;
  logic          o_axi_rd_req;
  logic [63:0]   o_axi_addr;
  logic [CW-1:0] o_miss_cnt;

  riscv_core_icache_controller #(.CNT_WIDTH(CW)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_addr_from_core (addr),
    .i_req            (req),
    .i_flush          (flush),
    .o_stall          (o_stall),
    .o_fetch_err      (o_fetch_err),
    .o_rd_en          (o_rd_en),
    .o_wr_en          (o_wr_en),
    .o_block_replace  (o_block_replace),
    .o_offset         (o_offset),
    .o_axi_rd_req     (o_axi_rd_req),
    .o_axi_addr       (o_axi_addr),
    .i_axi_rd_valid   (axv),
    .i_axi_rd_err     (axe),
    .o_miss_cnt       (o_miss_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Model: each set remembers the block base address it holds.
  bit [63:0]   mblk [128];
  bit          mval [128];
  bit          m_refill, m_sel, m_fp;
  bit [63:0]   m_raddr;
  bit [CW-1:0] m_cnt;
  bit          e_stall, e_rd, e_wr, e_off, e_err, e_req;
  bit          h0, hit;
  logic [63:0] b0, b2;
  int          idxs [5] = '{0, 1, 2, 126, 127};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic bit cached(input logic [63:0] b);
    int s;
    s = int'((b >> 5) & 64'd127);
    return mval[s] && (mblk[s] == b);
  endfunction

  task automatic lookup(input logic [63:0] a, output bit oh0, output bit ohit,
                        output logic [63:0] ob0, output logic [63:0] ob2);
    logic [63:0] a0, a2;
    a0   = a & ~64'd1;
    a2   = a0 + 64'd2;
    ob0  = a0 & ~64'd31;
    ob2  = a2 & ~64'd31;
    oh0  = cached(ob0);
    ohit = oh0 && ((ob0 == ob2) || cached(ob2));
  endtask

  task automatic clear_model_cache();
    for (int s = 0; s < 128; s++) mval[s] = 1'b0;
  endtask

  // Compare process: check outputs mid-cycle, then advance the model across
  // the coming rising edge using the inputs held for this cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        chk("rst_ctrl", {o_stall, o_fetch_err, o_rd_en, o_wr_en, o_block_replace,
                         o_offset, o_axi_rd_req}, 64'd0);
        chk("rst_addr", o_axi_addr, 64'd0);
        chk("rst_cnt", o_miss_cnt, 64'd0);
        clear_model_cache();
        m_refill = 0; m_fp = 0; m_sel = 0; m_raddr = '0; m_cnt = '0; e_stall = 0;
      end else begin
        lookup(addr, h0, hit, b0, b2);
        e_rd = 0; e_wr = 0; e_off = 0; e_err = 0; e_req = 0;
        if (m_refill) begin
          e_stall = 1; e_req = 1;
          e_wr = axv && !axe; e_off = e_wr && m_sel; e_err = axv && axe;
        end else if (m_fp) begin
          e_stall = 1;
        end else begin
          e_stall = req && !hit;
          e_rd    = req && hit;
        end
        chk("stall", o_stall, 64'(e_stall));
        chk("rd_en", o_rd_en, 64'(e_rd));
        chk("wr_en", o_wr_en, 64'(e_wr));
        chk("block_replace", o_block_replace, 64'(e_wr));
        chk("offset", o_offset, 64'(e_off));
        chk("fetch_err", o_fetch_err, 64'(e_err));
        chk("axi_rd_req", o_axi_rd_req, 64'(e_req));
        chk("miss_cnt", o_miss_cnt, 64'(m_cnt));
        if (m_refill) chk("axi_addr", o_axi_addr, m_raddr);

        if (m_refill) begin
          if (flush) m_fp = 1;
          if (axv) begin
            if (!axe) begin
              mval[int'((m_raddr >> 5) & 64'd127)] = 1'b1;
              mblk[int'((m_raddr >> 5) & 64'd127)] = m_raddr;
            end
            m_refill = 0;
          end
        end else if (m_fp) begin
          clear_model_cache();
          m_fp = 0;
        end else begin
          if (req && !hit) begin
            m_refill = 1;
            m_sel    = h0;
            m_raddr  = h0 ? b2 : b0;
            if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
          end
          if (flush) clear_model_cache();
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic [63:0] a, input logic f,
                     input logic v, input logic e);
    @(negedge clk);
    req = r; addr = a; flush = f; axv = v; axe = e;
    #3;
  endtask

  function automatic logic [63:0] gen_addr();
    logic [63:0] t;
    int          k;
    k = $urandom_range(0, 4);
    t = (k == 4) ? 64'h000F_FFFF_FFFF_FFFF : 64'(k);
    return (t << 12) | (64'(idxs[$urandom_range(0, 4)]) << 5) |
           (64'($urandom_range(0, 15)) << 1) | 64'($urandom_range(0, 1));
  endfunction

  initial begin
    rst_n = 0; req = 1; addr = 64'h1000; flush = 0; axv = 0; axe = 0;
    repeat (2) @(negedge clk);
    #3;
    chk("lit_rst_stall", o_stall, 64'd0);
    chk("lit_rst_axi_req", o_axi_rd_req, 64'd0);
    chk("lit_rst_cnt", o_miss_cnt, 64'd0);

    // Cold start at 0x1000
    @(negedge clk); rst_n = 1; #3;
    chk("lit_cold_stall", o_stall, 64'd1);
    cyc(1, 64'h1000, 0, 0, 0);
    chk("lit_cold_axi_req", o_axi_rd_req, 64'd1);
    chk("lit_cold_axi_addr", o_axi_addr, 64'h1000);
    cyc(1, 64'h1000, 0, 1, 0);
    chk("lit_cold_wr", o_wr_en, 64'd1);
    chk("lit_cold_off", o_offset, 64'd0);
    cyc(1, 64'h1000, 0, 0, 0);
    chk("lit_cold_rd", o_rd_en, 64'd1);
    chk("lit_cold_nostall", o_stall, 64'd0);
    chk("lit_cold_cnt", o_miss_cnt, 64'd1);
    chk("lit_axi_req_drop", o_axi_rd_req, 64'd0);

    // Spanning fetch, first block already present
    cyc(1, 64'h101E, 0, 0, 0);
    chk("lit_span_stall", o_stall, 64'd1);
    cyc(1, 64'h101E, 0, 1, 0);
    chk("lit_span_axi_addr", o_axi_addr, 64'h1020);
    chk("lit_span_off", o_offset, 64'd1);
    cyc(1, 64'h101E, 0, 0, 0);
    chk("lit_span_rd", o_rd_en, 64'd1);

    // Cold spanning fetch: two refills
    cyc(1, 64'h203E, 0, 0, 0);
    cyc(1, 64'h203E, 0, 1, 0);
    chk("lit_dbl_addr0", o_axi_addr, 64'h2020);
    chk("lit_dbl_off0", o_offset, 64'd0);
    cyc(1, 64'h203E, 0, 0, 0);
    chk("lit_dbl_restall", o_stall, 64'd1);
    cyc(1, 64'h203E, 0, 1, 0);
    chk("lit_dbl_addr1", o_axi_addr, 64'h2040);
    chk("lit_dbl_off1", o_offset, 64'd1);
    cyc(1, 64'h203E, 0, 0, 0);
    chk("lit_dbl_rd", o_rd_en, 64'd1);
    chk("lit_dbl_cnt", o_miss_cnt, 64'd4);

    // Conflict on set 0
    cyc(1, 64'h2000, 0, 0, 0);
    cyc(1, 64'h2000, 0, 1, 0);
    cyc(1, 64'h2000, 0, 0, 0);
    chk("lit_conf_rd", o_rd_en, 64'd1);
    cyc(1, 64'h1000, 0, 0, 0);
    chk("lit_conf_evicted", o_stall, 64'd1);
    cyc(1, 64'h1000, 0, 1, 0);
    cyc(1, 64'h1000, 0, 0, 0);

    // Flush during refill, then an error refill
    cyc(1, 64'h3000, 0, 0, 0);
    cyc(1, 64'h3000, 1, 0, 0);
    cyc(1, 64'h3000, 0, 1, 0);
    chk("lit_flush_wr", o_wr_en, 64'd1);
    cyc(1, 64'h3000, 0, 0, 0);
    chk("lit_flush_stall", o_stall, 64'd1);
    chk("lit_flush_nord", o_rd_en, 64'd0);
    cyc(1, 64'h3000, 0, 0, 0);
    chk("lit_flush_remiss", o_stall, 64'd1);
    cyc(1, 64'h3000, 0, 1, 1);
    chk("lit_err_pulse", o_fetch_err, 64'd1);
    chk("lit_err_nowr", o_wr_en, 64'd0);
    cyc(1, 64'h3000, 0, 0, 0);
    chk("lit_err_pulse_end", o_fetch_err, 64'd0);
    chk("lit_err_restall", o_stall, 64'd1);
    cyc(1, 64'h3000, 0, 1, 0);
    cyc(1, 64'h3000, 0, 0, 0);
    chk("lit_err_cnt", o_miss_cnt, 64'd9);
    cyc(1, 64'h1000, 0, 0, 0);
    chk("lit_flushed_1000", o_stall, 64'd1);
    cyc(1, 64'h1000, 0, 1, 0);
    cyc(0, 64'h0, 0, 0, 0);
    chk("lit_noreq", o_stall, 64'd0);

    // Randomized traffic; the core holds its request while stalled.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!(req && e_stall)) begin
        req  = ($urandom_range(0, 4) != 0);
        addr = gen_addr();
      end
      flush = ($urandom_range(0, 39) == 0);
      axv   = m_refill && ($urandom_range(0, 2) == 0);
      axe   = axv && ($urandom_range(0, 5) == 0);
    end

    req = 0; flush = 0; axe = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      axv = m_refill;
      if (!m_refill && !m_fp) break;
    end
    #3;
    chk("drain_timeout", o_axi_rd_req, 64'd0);
    chk("lit_sat_before", o_miss_cnt, 64'd15);

    cyc(0, 64'h0, 1, 0, 0);
    cyc(1, 64'h5000, 0, 0, 0);
    chk("lit_sat_miss_stall", o_stall, 64'd1);
    cyc(1, 64'h5000, 0, 0, 0);
    chk("lit_sat_hold", o_miss_cnt, 64'd15);
    chk("lit_sat_refill", o_axi_rd_req, 64'd1);

    // Asynchronous reset in the middle of a refill beat
    @(negedge clk);
    axv = 1;
    #1 rst_n = 0;
    #1;
    chk("lit_rst_mid_axi_req", o_axi_rd_req, 64'd0);
    chk("lit_rst_mid_wr", o_wr_en, 64'd0);
    repeat (2) @(negedge clk);
    #4;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
